// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and divide-by-zero policy for the
// execute-stage ALU with iterative multiply/divide.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Divide by zero: quotient saturates to all-ones, remainder returns the dividend.
  localparam logic DIV0_LO_ONES     = 1'b1;
  localparam logic DIV0_HI_DIVIDEND = 1'b1;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 unsigned engine: shift/add multiplier and restoring divider sharing
// one adder. Loaded on start, advances one step per cycle while step_en.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             step_en,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;

  logic [WIDTH:0]   shifted, add_x, add_y;
  logic [WIDTH+1:0] sum;

  // Divide: shifted partial remainder minus divisor; carry out means no borrow.
  // Multiply: accumulator plus multiplicand when the current multiplier bit is set.
  always_comb begin
    shifted = {acc_q, mq_q[WIDTH-1]};
    add_x   = is_div_q ? shifted : {1'b0, acc_q};
    add_y   = is_div_q ? ~{1'b0, dvs_q} : (mq_q[0] ? {1'b0, dvs_q} : '0);
    sum     = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div_q};
  end

  always_comb begin
    acc_d    = acc_q;
    mq_d     = mq_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    if (start) begin
      acc_d    = '0;
      mq_d     = opa;
      dvs_d    = opb;
      cnt_d    = '0;
      is_div_d = is_div;
    end else if (step_en) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        if (sum[WIDTH+1]) begin
          acc_d = sum[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mq_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  // High during the cycle that performs the final step.
  assign done   = (cnt_q == CW'(WIDTH - 1));
  assign res_hi = acc_q;
  assign res_lo = mq_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops plus iterative mul/div into HI/LO.
// Handshake: an op transfers when in_valid && in_ready; out_valid is a one-cycle pulse with no backpressure.
module alu_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_e           dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, a_q, a_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             b_zero_q, b_zero_d;

  logic             accept, iter_start, iter_done, sgn;
  logic [WIDTH-1:0] a_mag, b_mag, it_hi, it_lo;
  logic [WIDTH-1:0] sum, diff, alu_res, quo, rem;
  logic             alu_ovf;
  logic [2*WIDTH-1:0] prod_mag, prod;

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_muldiv(op);
  assign sgn        = is_signed_op(op);
  assign a_mag      = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag      = (sgn && b[WIDTH-1]) ? -b : b;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (iter_start),
    .is_div  (is_div_op(op)),
    .opa     (a_mag),
    .opb     (b_mag),
    .step_en (state_q == S_ITER),
    .done    (iter_done),
    .res_hi  (it_hi),
    .res_lo  (it_lo)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  alu_res = ~(a | b);
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_SRA:  alu_res = $signed(a) >>> b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Sign fix-up of the unsigned engine output.
  always_comb begin
    prod_mag = {it_hi, it_lo};
    prod     = neg_res_q ? -prod_mag : prod_mag;
    quo      = neg_res_q ? -it_lo : it_lo;
    rem      = neg_rem_q ? -it_hi : it_hi;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    a_d         = a_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    b_zero_d    = b_zero_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_muldiv(op)) begin
              state_d   = S_ITER;
              a_d       = a;
              is_div_d  = is_div_op(op);
              neg_res_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = sgn && a[WIDTH-1];
              b_zero_d  = (b == '0);
            end else begin
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              ovf_d       = alu_ovf;
              out_valid_d = 1'b1;
            end
          end
        end
        S_ITER: begin
          if (iter_done) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          if (is_div_q) begin
            if (b_zero_q) begin
              lo_d = DIV0_LO_ONES ? '1 : '0;
              hi_d = DIV0_HI_DIVIDEND ? a_q : '0;
            end else begin
              lo_d = quo;
              hi_d = rem;
            end
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          result_d    = lo_d;
          zero_d      = (lo_d == '0);
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      b_zero_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      a_q         <= a_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      b_zero_q    <= b_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32): single-cycle ops, mul/div latency,
// divide corner cases, flush and mid-operation reset.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, ovf;
  logic [31:0] hi, lo;
  state_e      dbg_state;

  int vectors;
  int miscompares;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_result"}, result, 32'h0);
    chk({pfx, "_hi"}, hi, 32'h0);
    chk({pfx, "_lo"}, lo, 32'h0);
    chk({pfx, "_zero"}, zero, 1);
    chk({pfx, "_ovf"}, ovf, 0);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_ready"}, in_ready, 1);
    chk({pfx, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Offer one single-cycle op in cycle N and check its result in cycle N+1.
  task automatic run_single(input string tag, input logic [3:0] o, input logic [31:0] x, y,
                            input logic [31:0] exp_res, input logic exp_ovf);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, zero, (exp_res == 32'h0));
    chk({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  // Offer a mul/div op in cycle N, scramble inputs while busy, expect the pulse at N+34.
  task automatic run_muldiv(input string tag, input logic [3:0] o, input logic [31:0] x, y,
                            input logic [31:0] exp_hi, exp_lo);
    int cyc;
    int rdy_busy;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    cyc = 1;
    rdy_busy = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) rdy_busy++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 34);
    chk({tag, "_busy_ready"}, rdy_busy, 0);
    chk({tag, "_ready_at_pulse"}, in_ready, 1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_res"}, result, exp_lo);
    chk({tag, "_zero"}, zero, (exp_lo == 32'h0));
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    run_single("slt",  OP_SLT,  32'h8000_0000, 32'h1, 32'h1, 1'b0);
    run_single("sltu", OP_SLTU, 32'h8000_0000, 32'h1, 32'h0, 1'b0);
    run_single("sra",  OP_SRA,  32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0);
    run_single("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    run_single("sub_zero", OP_SUB, 32'h5, 32'h5, 32'h0, 1'b0);
    run_single("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    run_single("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    run_single("sll", OP_SLL, 32'h1, 32'h1F, 32'h8000_0000, 1'b0);

    // Three back-to-back accepts, three consecutive pulses, then idle.
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_AND; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
    @(posedge clk); #1;
    op = OP_NOR; a = 32'h0; b = 32'h0;
    @(negedge clk);
    chk("b2b_and_valid", out_valid, 1);
    chk("b2b_and_res", result, 32'hF000_F000);
    @(posedge clk); #1;
    op = OP_SRL; a = 32'h8000_0000; b = 32'h1F;
    @(negedge clk);
    chk("b2b_nor_valid", out_valid, 1);
    chk("b2b_nor_res", result, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_srl_valid", out_valid, 1);
    chk("b2b_srl_res", result, 32'h1);
    @(negedge clk);
    chk("b2b_pulse_end", out_valid, 0);

    run_muldiv("mult",  OP_MULT,  32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_muldiv("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
    run_muldiv("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_muldiv("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_muldiv("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_muldiv("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);

    run_single("rsvd", OP_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0);
    chk("rsvd_hi", hi, 32'd9);
    chk("rsvd_lo", lo, 32'hFFFF_FFFF);

    // Flush in the same cycle as an offer: nothing accepted.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
    @(negedge clk);
    chk("flush_offer_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_offer_valid", out_valid, 0);
    chk("flush_offer_res", result, 32'h0);

    // DIVU accepted at N, flushed at N+10.
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ready_after", in_ready, 1);
    chk("flush_state_after", 32'(dbg_state), 32'(S_IDLE));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("flush_no_pulse", pulses, 0);
    chk("flush_hi_hold", hi, 32'd9);
    chk("flush_lo_hold", lo, 32'hFFFF_FFFF);

    // Reset asserted at N+5 of a MULT.
    @(posedge clk); #1;
    in_valid = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midop_reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("post_reset_no_pulse", pulses, 0);
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_lo", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
